sap_control_sequencer: RTL and testbench

- SAP-1 controller-sequencer: a one-hot T-state ring counter plus an opcode decoder.
- Drives the load (active-low, 74173 G-style) and output-enable strobes of the bus registers: MAR, IR, A, B, OUT. Also drives the PC and ALU controls.
- Sits directly upstream of every sn54173-based register. Its *_ld_n outputs connect to the registers' g1/g2 pins; its *_oe outputs drive the m/n and tri-state enables.
- Supports free-run and single-step operation, plus a sticky halt.

---
 rtl/sap_pkg.sv | 35 +++
 rtl/sap_ring_counter.sv | 24 ++
 rtl/sap_control_sequencer.sv | 119 +++++++++++
 tb/tb_sap_control_sequencer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// Shared constants for the SAP-1 controller-sequencer: opcodes, default sizing
// and the bit layout of the internal control word.
package sap_pkg;

    localparam int T_STATES_DEF = 6;
    localparam int OPCODE_W_DEF = 4;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // Control word bits are stored active-high; the top inverts the *_n strobes.
    localparam int CW_PC_INC  = 0;
    localparam int CW_PC_OE   = 1;
    localparam int CW_MAR_LD  = 2;
    localparam int CW_RAM_OE  = 3;
    localparam int CW_IR_LD   = 4;
    localparam int CW_IR_OE   = 5;
    localparam int CW_A_LD    = 6;
    localparam int CW_A_OE    = 7;
    localparam int CW_ALU_SUB = 8;
    localparam int CW_ALU_OE  = 9;
    localparam int CW_B_LD    = 10;
    localparam int CW_OUT_LD  = 11;
    localparam int CW_W       = 12;

    typedef logic [CW_W-1:0] cw_t;

    function automatic cw_t cw_bit(input int idx);
        cw_bit = {{(CW_W-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/sap_ring_counter.sv
// One-hot T-state ring counter; rotates only on qualified cycles.
module sap_ring_counter
    import sap_pkg::*;
#(
    parameter int N = T_STATES_DEF
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         adv,
    output logic [N-1:0] t_state
);

    // Rotate T1 -> TN -> T1 on adv, restart at T1 on clr low.
    always_ff @(posedge clk) begin
        if (!clr) begin
            t_state <= {{(N-1){1'b0}}, 1'b1};
        end else if (adv) begin
            t_state <= {t_state[N-2:0], t_state[N-1]};
        end else begin
            t_state <= t_state;
        end
    end

endmodule

// File: rtl/sap_control_sequencer.sv
// SAP-1 controller-sequencer: T-state ring, opcode decode, single-step and
// sticky halt. Strobes are gated by the advance qualifier so stalls assert nothing.
module sap_control_sequencer
    import sap_pkg::*;
#(
    parameter int T_STATES = T_STATES_DEF,
    parameter int OPCODE_W = OPCODE_W_DEF
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                run,
    input  logic                step,
    input  logic [OPCODE_W-1:0] opcode,
    output logic [T_STATES-1:0] t_state,
    output logic                halted,
    output logic                pc_inc,
    output logic                pc_oe,
    output logic                mar_ld_n,
    output logic                ram_oe_n,
    output logic                ir_ld_n,
    output logic                ir_oe_n,
    output logic                a_ld_n,
    output logic                a_oe,
    output logic                alu_sub,
    output logic                alu_oe,
    output logic                b_ld_n,
    output logic                out_ld_n
);

    logic [T_STATES-1:0] t_state_s;
    logic                halted_r;
    logic                step_q_r;
    logic                adv_s;
    logic                hlt_now_s;
    cw_t                 cw_s;

    assign adv_s = clr & ~halted_r & (run | (step & ~step_q_r));

    sap_ring_counter #(.N(T_STATES)) u_ring (
        .clk     (clk),
        .clr     (clr),
        .adv     (adv_s),
        .t_state (t_state_s)
    );

    // Opcode is masked by T4 first so an undriven IR during fetch cannot leak.
    assign hlt_now_s = t_state_s[3] & (opcode == OPCODE_W'(OP_HLT));

    // Step edge-detect register and sticky halt flag.
    always_ff @(posedge clk) begin
        if (!clr) begin
            step_q_r <= 1'b0;
            halted_r <= 1'b0;
        end else begin
            step_q_r <= step;
            if (adv_s && hlt_now_s) begin
                halted_r <= 1'b1;
            end else begin
                halted_r <= halted_r;
            end
        end
    end

    // Control word decode from T-state and opcode, only on advancing cycles.
    always_comb begin
        cw_s = {CW_W{1'b0}};
        if (adv_s) begin
            if (t_state_s[0]) begin
                cw_s = cw_bit(CW_PC_OE) | cw_bit(CW_MAR_LD);
            end else if (t_state_s[1]) begin
                cw_s = cw_bit(CW_PC_INC);
            end else if (t_state_s[2]) begin
                cw_s = cw_bit(CW_RAM_OE) | cw_bit(CW_IR_LD);
            end else if (t_state_s[3]) begin
                case (opcode)
                    OPCODE_W'(OP_LDA),
                    OPCODE_W'(OP_ADD),
                    OPCODE_W'(OP_SUB): cw_s = cw_bit(CW_IR_OE) | cw_bit(CW_MAR_LD);
                    OPCODE_W'(OP_OUT): cw_s = cw_bit(CW_A_OE) | cw_bit(CW_OUT_LD);
                    default:           cw_s = {CW_W{1'b0}};
                endcase
            end else if (t_state_s[4]) begin
                case (opcode)
                    OPCODE_W'(OP_LDA): cw_s = cw_bit(CW_RAM_OE) | cw_bit(CW_A_LD);
                    OPCODE_W'(OP_ADD),
                    OPCODE_W'(OP_SUB): cw_s = cw_bit(CW_RAM_OE) | cw_bit(CW_B_LD);
                    default:           cw_s = {CW_W{1'b0}};
                endcase
            end else if (t_state_s[5]) begin
                case (opcode)
                    OPCODE_W'(OP_ADD): cw_s = cw_bit(CW_ALU_OE) | cw_bit(CW_A_LD);
                    OPCODE_W'(OP_SUB): cw_s = cw_bit(CW_ALU_SUB) | cw_bit(CW_ALU_OE)
                                            | cw_bit(CW_A_LD);
                    default:           cw_s = {CW_W{1'b0}};
                endcase
            end else begin
                cw_s = {CW_W{1'b0}};
            end
        end else begin
            cw_s = {CW_W{1'b0}};
        end
    end

    assign t_state  = t_state_s;
    assign halted   = halted_r;
    assign pc_inc   =  cw_s[CW_PC_INC];
    assign pc_oe    =  cw_s[CW_PC_OE];
    assign mar_ld_n = ~cw_s[CW_MAR_LD];
    assign ram_oe_n = ~cw_s[CW_RAM_OE];
    assign ir_ld_n  = ~cw_s[CW_IR_LD];
    assign ir_oe_n  = ~cw_s[CW_IR_OE];
    assign a_ld_n   = ~cw_s[CW_A_LD];
    assign a_oe     =  cw_s[CW_A_OE];
    assign alu_sub  =  cw_s[CW_ALU_SUB];
    assign alu_oe   =  cw_s[CW_ALU_OE];
    assign b_ld_n   = ~cw_s[CW_B_LD];
    assign out_ld_n = ~cw_s[CW_OUT_LD];

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Directed table of per-cycle vectors for the SAP-1 sequencer, followed by a
// random-opcode soak for one-hot and bus-exclusivity properties.
module tb_sap_control_sequencer;

    logic       clk = 1'b0;
    logic       clr, run, step;
    logic [3:0] opcode;
    logic [5:0] t_state;
    logic       halted, pc_inc, pc_oe, mar_ld_n, ram_oe_n, ir_ld_n, ir_oe_n;
    logic       a_ld_n, a_oe, alu_sub, alu_oe, b_ld_n, out_ld_n;

    always #5 clk = ~clk;

    sap_control_sequencer #(.T_STATES(6), .OPCODE_W(4)) dut (
        .clk(clk), .clr(clr), .run(run), .step(step), .opcode(opcode),
        .t_state(t_state), .halted(halted), .pc_inc(pc_inc), .pc_oe(pc_oe),
        .mar_ld_n(mar_ld_n), .ram_oe_n(ram_oe_n), .ir_ld_n(ir_ld_n),
        .ir_oe_n(ir_oe_n), .a_ld_n(a_ld_n), .a_oe(a_oe), .alu_sub(alu_sub),
        .alu_oe(alu_oe), .b_ld_n(b_ld_n), .out_ld_n(out_ld_n)
    );

    // Asserted-strobe set, one bit per strobe regardless of pin polarity.
    localparam logic [11:0] S_PCI = 12'h800, S_PCO = 12'h400, S_MAR = 12'h200;
    localparam logic [11:0] S_RAM = 12'h100, S_IRL = 12'h080, S_IRO = 12'h040;
    localparam logic [11:0] S_AL  = 12'h020, S_AO  = 12'h010, S_SUB = 12'h008;
    localparam logic [11:0] S_ALU = 12'h004, S_BL  = 12'h002, S_OL  = 12'h001;
    localparam logic [11:0] S_NONE = 12'h000;

    localparam logic [5:0] T1 = 6'b000001, T2 = 6'b000010, T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000, T5 = 6'b010000, T6 = 6'b100000;

    typedef struct {
        logic       clr;
        logic       run;
        logic       step;
        logic [3:0] op;
        int         reps;
        logic [5:0] t;
        logic       h;
        logic [11:0] s;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic logic [11:0] act();
        return {pc_inc, pc_oe, ~mar_ld_n, ~ram_oe_n, ~ir_ld_n, ~ir_oe_n,
                ~a_ld_n, a_oe, alu_sub, alu_oe, ~b_ld_n, ~out_ld_n};
    endfunction

    task automatic add(input logic c, input logic r, input logic s, input logic [3:0] o,
                       input int reps, input logic [5:0] t, input logic h,
                       input logic [11:0] st);
        vec_t v;
        v.clr = c; v.run = r; v.step = s; v.op = o; v.reps = reps;
        v.t = t; v.h = h; v.s = st;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    initial begin
        // LDA, SUB, ADD, OUT, other-NOP instructions in free-run
        add(0,1,0,4'h0,1,T1,0,S_NONE);
        add(1,1,0,4'h0,1,T1,0,S_PCO|S_MAR);
        add(1,1,0,4'h0,1,T2,0,S_PCI);
        add(1,1,0,4'h0,1,T3,0,S_RAM|S_IRL);
        add(1,1,0,4'h0,1,T4,0,S_IRO|S_MAR);
        add(1,1,0,4'h0,1,T5,0,S_RAM|S_AL);
        add(1,1,0,4'h0,1,T6,0,S_NONE);
        add(1,1,0,4'h2,1,T1,0,S_PCO|S_MAR);
        add(1,1,0,4'hF,1,T2,0,S_PCI);
        add(1,1,0,4'h2,1,T3,0,S_RAM|S_IRL);
        add(1,1,0,4'h2,1,T4,0,S_IRO|S_MAR);
        add(1,1,0,4'h2,1,T5,0,S_RAM|S_BL);
        add(1,1,0,4'h2,1,T6,0,S_SUB|S_ALU|S_AL);
        add(1,1,0,4'h1,1,T1,0,S_PCO|S_MAR);
        add(1,1,0,4'h7,1,T2,0,S_PCI);
        add(1,1,0,4'h1,1,T3,0,S_RAM|S_IRL);
        add(1,1,0,4'h1,1,T4,0,S_IRO|S_MAR);
        add(1,1,0,4'h1,1,T5,0,S_RAM|S_BL);
        add(1,1,0,4'h1,1,T6,0,S_ALU|S_AL);
        add(1,1,0,4'hE,1,T1,0,S_PCO|S_MAR);
        add(1,1,0,4'hE,1,T2,0,S_PCI);
        add(1,1,0,4'hE,1,T3,0,S_RAM|S_IRL);
        add(1,1,0,4'hE,1,T4,0,S_AO|S_OL);
        add(1,1,0,4'hE,1,T5,0,S_NONE);
        add(1,1,0,4'hE,1,T6,0,S_NONE);
        add(1,1,0,4'h5,1,T1,0,S_PCO|S_MAR);
        add(1,1,0,4'h5,1,T2,0,S_PCI);
        add(1,1,0,4'h5,1,T3,0,S_RAM|S_IRL);
        add(1,1,0,4'h5,1,T4,0,S_NONE);
        add(1,1,0,4'h5,1,T5,0,S_NONE);
        add(1,1,0,4'h5,1,T6,0,S_NONE);
        // HLT: advances to T5 then freezes until clr
        add(1,1,0,4'hF,1,T1,0,S_PCO|S_MAR);
        add(1,1,0,4'hF,1,T2,0,S_PCI);
        add(1,1,0,4'hF,1,T3,0,S_RAM|S_IRL);
        add(1,1,0,4'hF,1,T4,0,S_NONE);
        add(1,1,1,4'hF,20,T5,1,S_NONE);
        add(0,1,0,4'hF,1,T5,1,S_NONE);
        add(1,0,0,4'h0,1,T1,0,S_NONE);
        // single-step: held step advances once, pc_inc on one cycle only
        add(1,0,1,4'h0,1,T1,0,S_PCO|S_MAR);
        add(1,0,1,4'h0,4,T2,0,S_NONE);
        add(1,0,0,4'h0,1,T2,0,S_NONE);
        add(1,0,1,4'h0,1,T2,0,S_PCI);
        add(1,0,1,4'h0,1,T3,0,S_NONE);
        add(1,0,0,4'h0,1,T3,0,S_NONE);
        // reset in T5 of LDA suppresses a_ld_n
        add(1,1,0,4'h0,1,T3,0,S_RAM|S_IRL);
        add(1,1,0,4'h0,1,T4,0,S_IRO|S_MAR);
        add(0,1,0,4'h0,1,T5,0,S_NONE);
        add(1,0,0,4'h0,1,T1,0,S_NONE);
        // reset clears the step edge detector
        add(0,0,1,4'h0,1,T1,0,S_NONE);
        add(1,0,1,4'h0,1,T1,0,S_PCO|S_MAR);
        add(1,0,1,4'h0,1,T2,0,S_NONE);

        clr = 1'b0; run = 1'b0; step = 1'b0; opcode = 4'h0;
        repeat (2) @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                clr = vecs[i].clr; run = vecs[i].run;
                step = vecs[i].step; opcode = vecs[i].op;
                @(negedge clk);
                check($sformatf("v%0d.%0d t_state", i, r), {6'b0, t_state}, {6'b0, vecs[i].t});
                check($sformatf("v%0d.%0d halted", i, r), {11'b0, halted}, {11'b0, vecs[i].h});
                check($sformatf("v%0d.%0d strobes", i, r), act(), vecs[i].s);
                @(posedge clk);
                #1;
            end
        end

        // random soak; clr pulses whenever halted or at random
        for (int k = 0; k < 1000; k++) begin
            clr    = (halted || ($urandom_range(0, 49) == 0)) ? 1'b0 : 1'b1;
            run    = 1'($urandom_range(0, 1));
            step   = 1'($urandom_range(0, 1));
            opcode = 4'($urandom_range(0, 15));
            @(negedge clk);
            n_cmp++;
            if (!$onehot(t_state)) begin
                n_fail++;
                $display("FAIL rnd%0d onehot: got %b expected one-hot", k, t_state);
            end
            n_cmp++;
            assert ($countones({pc_oe, ~ram_oe_n, ~ir_oe_n, a_oe, alu_oe}) <= 1)
            else begin
                n_fail++;
                $display("FAIL rnd%0d bus_excl: got oe set %b expected at most one",
                         k, {pc_oe, ~ram_oe_n, ~ir_oe_n, a_oe, alu_oe});
            end
            if (!clr || halted) begin
                check($sformatf("rnd%0d idle strobes", k), act(), S_NONE);
            end
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
